ahb_fill_master: RTL and testbench
==================================

// Module: ahb_fill_master
// PURPOSE
//  AHB-Lite initiator that writes a programmable run of 32-bit words to consecutive
//  slave addresses, e.g. filling/clearing the VGA image buffer or pushing console text.
//  It is the master-side counterpart of the system's AHB-Lite slave peripherals.
//  Transfers are single NONSEQ word writes, pipelined (address of beat k+1 overlaps data of beat k).
//  Fully honours HREADY wait states (e.g. console scroll stalls) and two-cycle HRESP errors.
// PARAMETERS
//  ADDR_STEP  4   byte increment of HADDR between beats (multiple of 4)
//  LEN_W      16  width of the beat-count input
// PORTS
//  HCLK       in   1      system clock; all logic on rising edge
//  HRESETn    in   1      asynchronous active-low reset
//  start      in   1      1-cycle request; sampled only when busy=0
//  base_addr  in   32     first write address (word aligned); sampled with start
//  length     in   LEN_W  number of beats; sampled with start
//  fill_data  in   32     data of beat 0; sampled with start
//  data_inc   in   32     added to data each beat (0 = constant fill); sampled with start
//  busy       out  1      high from cycle after accepted start until done
//  done       out  1      1-cycle pulse at end of run (normal, empty or error)
//  error      out  1      set with done if run ended on HRESP=ERROR; cleared by next start
//  HADDR      out  32     AHB address
//  HTRANS     out  2      2'b00 IDLE or 2'b10 NONSEQ only
//  HWRITE     out  1      1 whenever HTRANS=NONSEQ, else 0
//  HSIZE      out  3      constant 3'b010 (word)
//  HBURST     out  3      constant 3'b000 (SINGLE)
//  HPROT      out  4      constant 4'b0011
//  HMASTLOCK  out  1      constant 0
//  HWDATA     out  32     write data, valid in data phase
//  HREADY     in   1      transfer-complete from interconnect
//  HRESP      in   1      0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset (async): HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, FSM=IDLE.
//  All bus outputs registered. States IDLE, ADDR, PIPE, LAST, ERR.
//  IDLE: start & length!=0 -> ADDR; next cycle HTRANS=NONSEQ, HADDR=base_addr, busy=1, error=0.
//    start & length==0 -> done=1 next cycle, error=0, no bus activity, stay IDLE.
//  ADDR/PIPE: address phase is accepted on an edge with HREADY=1; on that edge HWDATA<=data
//    of the accepted beat; if beats remain, HADDR<=HADDR+ADDR_STEP, data<=data+data_inc,
//    HTRANS stays NONSEQ (PIPE); else HTRANS<=IDLE (LAST).
//  HREADY=0: HADDR, HTRANS, HWDATA and the data/beat counters hold unchanged.
//  LAST: on HREADY=1 with HRESP=0 -> IDLE, busy<=0, done<=1 for one cycle.
//  Error: HRESP=1 with HREADY=0 in a data phase -> HTRANS<=IDLE next cycle (pending beat
//    cancelled), go ERR; in ERR on HREADY=1 -> IDLE, done=1, error=1, busy=0. No retry.
//  Arithmetic: HADDR and data wrap modulo 2^32; beat counter LEN_W bits, length=2^LEN_W-1 legal.
//  start while busy=1 ignored (no effect on run or sampled values).
//  Zero wait states: start at edge 0 -> NONSEQ at cycles 1..N, data cycles 2..N+1, done cycle N+2.
//  error holds its value until the next accepted start or reset.
// TESTING
//  base=0x5000_0010, len=4, fill=0x11, inc=1, HREADY=1 -> HADDR 10,14,18,1C; HWDATA 11..14; done cycle 6.
//  Same run, HREADY low 3 cycles during beat 2 data phase -> outputs frozen, beat 3 addr held, done at 9.
//  len=0 -> done next cycle, error=0, HTRANS stays IDLE throughout.
//  len=4, HRESP=1 (2 cycles) on beat 1 data -> HTRANS IDLE next cycle, beat 2 never issued, done+error=1.
//  start pulsed mid-run with new base -> ignored; base=0xFFFF_FFFC len=2 -> HADDR FFFF_FFFC then 0000_0000.
//  HRESETn low mid-run -> HTRANS IDLE, busy=0 immediately; fresh start afterwards runs normally.

Source files
------------

// File: rtl/ahb_fill_master.sv
// ahb_fill_master
// -----------------------------------------------------------------------------
// AHB-Lite initiator that writes a programmable run of 32-bit words to
// consecutive slave addresses (frame-buffer fill/clear, console text push).
// Every beat is a single NONSEQ word write; beats are pipelined so that the
// address phase of beat k+1 overlaps the data phase of beat k.  HREADY wait
// states stall the whole pipeline; a two-cycle HRESP=ERROR response cancels
// any pending address phase and ends the run with error=1 (no retry).
//
// Handshake: a run is requested by a one-cycle start pulse, sampled only while
// busy=0.  busy rises the cycle after an accepted start and falls in the same
// cycle that done pulses.  On the AHB side, a phase completes on a rising edge
// where HREADY=1; while HREADY=0 every bus output and internal counter holds.
//
// Ports
//   HCLK, HRESETn        clock (rising edge) and asynchronous active-low reset
//   start                one-cycle run request
//   base_addr            first write address (word aligned), sampled with start
//   length               number of beats (0 = empty run), sampled with start
//   fill_data            data of beat 0, sampled with start
//   data_inc             per-beat data increment, sampled with start
//   busy, done, error    run status (done is a one-cycle pulse; error is sticky
//                        until the next accepted start)
//   HADDR..HMASTLOCK     AHB-Lite master address/control outputs (registered)
//   HWDATA               write data, valid in the data phase
//   HREADY, HRESP        transfer-complete and response from the interconnect
// -----------------------------------------------------------------------------
module ahb_fill_master #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      fill_data,
    input  logic [31:0]      data_inc,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    localparam logic [1:0]       TRANS_IDLE   = 2'b00;
    localparam logic [1:0]       TRANS_NONSEQ = 2'b10;
    localparam logic [31:0]      STEP         = 32'(ADDR_STEP);
    localparam logic [LEN_W-1:0] ONE_BEAT     = LEN_W'(1);

    // S_ADDR : first address phase, no data phase of ours in flight yet
    // S_PIPE : address phase of beat k+1 overlapping data phase of beat k
    // S_LAST : data phase of the final beat, bus address phase idle
    // S_ERR  : second cycle of an ERROR response
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PIPE,
        S_LAST,
        S_ERR
    } state_t;

    state_t           state;
    logic [31:0]      data_q;   // data of the beat currently in its address phase
    logic [31:0]      inc_q;
    logic [LEN_W-1:0] beats_q;  // address phases still to be accepted, incl. current

    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            HADDR   <= '0;
            HTRANS  <= TRANS_IDLE;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            data_q  <= '0;
            inc_q   <= '0;
            beats_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        if (length != '0) begin
                            state   <= S_ADDR;
                            HTRANS  <= TRANS_NONSEQ;
                            HWRITE  <= 1'b1;
                            HADDR   <= base_addr;
                            data_q  <= fill_data;
                            inc_q   <= data_inc;
                            beats_q <= length;
                            busy    <= 1'b1;
                        end else begin
                            // Empty run: report completion without touching the bus.
                            done <= 1'b1;
                        end
                    end
                end

                S_ADDR, S_PIPE: begin
                    if (state == S_PIPE && !HREADY && HRESP) begin
                        // First ERROR cycle on the previous beat: drop the
                        // pending address phase so it is never transferred.
                        HTRANS <= TRANS_IDLE;
                        HWRITE <= 1'b0;
                        state  <= S_ERR;
                    end else if (HREADY) begin
                        HWDATA <= data_q;
                        if (beats_q == ONE_BEAT) begin
                            HTRANS <= TRANS_IDLE;
                            HWRITE <= 1'b0;
                            state  <= S_LAST;
                        end else begin
                            HADDR   <= HADDR + STEP;
                            data_q  <= data_q + inc_q;
                            beats_q <= beats_q - ONE_BEAT;
                            state   <= S_PIPE;
                        end
                    end
                end

                S_LAST: begin
                    if (HREADY) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= HRESP;
                    end else if (HRESP) begin
                        state <= S_ERR;
                    end
                end

                S_ERR: begin
                    if (HREADY) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_fill_master.sv
`timescale 1ns/1ps
module tb_ahb_fill_master;

    localparam int LEN_W     = 16;
    localparam int ADDR_STEP = 4;

    // ---------------- clock / reset / DUT ----------------
    logic             HCLK      = 1'b0;
    logic             HRESETn   = 1'b0;
    logic             start     = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [LEN_W-1:0] length    = '0;
    logic [31:0]      fill_data = '0;
    logic [31:0]      data_inc  = '0;
    logic             busy, done, error;
    logic [31:0]      HADDR, HWDATA;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE, HBURST;
    logic [3:0]       HPROT;
    logic             HMASTLOCK;
    logic             HREADY    = 1'b1;
    logic             HRESP     = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_fill_master #(.ADDR_STEP(ADDR_STEP), .LEN_W(LEN_W)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .fill_data (fill_data),
        .data_inc  (data_inc),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];      // {addr, data} of every write expected to complete OKAY
    logic        exp_end_q[$];  // expected error flag at each done pulse

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // ---------------- slave model (drives HREADY/HRESP at negedge) ----------------
    int err_beat    = -1;  // beat index whose data phase gets an ERROR response
    int wait_beat   = -1;  // beat index that gets wait_n wait states
    int wait_n      = 0;
    bit rand_waits  = 1'b0;
    bit idle_stalls = 1'b0;
    int beat_cnt    = 0;   // address phases accepted in the current run

    initial begin
        bit s_dp    = 1'b0;
        bit s_err   = 1'b0;
        int s_beat  = 0;
        int s_waits = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                s_dp   = 1'b0;
                s_err  = 1'b0;
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end else begin
                if (s_dp) begin
                    if (s_err) begin
                        HREADY = 1'b1;
                        HRESP  = 1'b1;
                    end else if (s_beat == err_beat) begin
                        HREADY = 1'b0;
                        HRESP  = 1'b1;
                        s_err  = 1'b1;
                    end else if (s_waits > 0) begin
                        HREADY = 1'b0;
                        HRESP  = 1'b0;
                        s_waits--;
                    end else begin
                        HREADY = 1'b1;
                        HRESP  = 1'b0;
                    end
                end else begin
                    HRESP  = 1'b0;
                    HREADY = idle_stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (HREADY) begin
                    s_err = 1'b0;
                    s_dp  = (HTRANS == 2'b10);
                    if (s_dp) begin
                        s_beat = beat_cnt;
                        beat_cnt++;
                        if (s_beat == wait_beat) s_waits = wait_n;
                        else if (rand_waits)     s_waits = $urandom_range(0, 2);
                        else                     s_waits = 0;
                    end
                end
            end
        end
    end

    // ---------------- monitor: bus observation and scoreboard compare ----------------
    initial begin
        bit          m_dp    = 1'b0;
        logic [31:0] m_addr  = '0;
        bit          p_valid = 1'b0;
        bit          p_dp    = 1'b0;
        logic [1:0]  p_trans = '0;
        logic [31:0] p_addr  = '0;
        logic [31:0] p_wdata = '0;
        logic        p_ready = 1'b1;
        logic        p_resp  = 1'b0;
        logic [63:0] e;
        forever begin
            @(negedge HCLK);
            #1;
            if (!HRESETn) begin
                m_dp    = 1'b0;
                p_valid = 1'b0;
                continue;
            end
            // a plain wait state must freeze the pipeline
            if (p_valid && !p_ready && !p_resp) begin
                if (p_trans == 2'b10) begin
                    check("hold_haddr", HADDR, p_addr);
                    check("hold_htrans", HTRANS, p_trans);
                end
                if (p_dp) check("hold_hwdata", HWDATA, p_wdata);
            end
            // data phase completing this cycle
            if (m_dp && HREADY && !HRESP) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_write", $sformatf("addr %0h data %0h, none required", m_addr, HWDATA));
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", m_addr, e[63:32]);
                    check("write_data", HWDATA, e[31:0]);
                end
            end
            if (HTRANS == 2'b10) begin
                check("hwrite_nonseq", HWRITE, 1'b1);
                check("hsize", HSIZE, 3'b010);
                check("hburst", HBURST, 3'b000);
                check("hprot", HPROT, 4'b0011);
                check("hmastlock", HMASTLOCK, 1'b0);
            end else begin
                check("htrans_idle", HTRANS, 2'b00);
                check("hwrite_idle", HWRITE, 1'b0);
            end
            if (done) begin
                if (exp_end_q.size() == 0) fail("unexpected_done", "done pulse with no run pending");
                else check("done_error", error, exp_end_q.pop_front());
                check("done_busy", busy, 1'b0);
            end
            p_dp = m_dp;
            if (HREADY) begin
                m_dp   = (HTRANS == 2'b10);
                m_addr = HADDR;
            end
            p_valid = 1'b1;
            p_trans = HTRANS;
            p_addr  = HADDR;
            p_wdata = HWDATA;
            p_ready = HREADY;
            p_resp  = HRESP;
        end
    end

    // ---------------- driver: one run, with reference model pushes ----------------
    // exp_done < 0 means latency is not checked (random wait states).
    task automatic run(input logic [31:0] b, input int n, input logic [31:0] f,
                       input logic [31:0] inc, input int eb, input int exp_done,
                       input bit mid_start);
        int  n_ok;
        int  cyc;
        bit  exp_err;
        exp_err = (eb >= 0 && eb < n);
        n_ok    = exp_err ? eb : n;
        for (int k = 0; k < n_ok; k++)
            exp_q.push_back({b + 32'(k * ADDR_STEP), f + 32'(k) * inc});
        exp_end_q.push_back(exp_err);

        @(negedge HCLK);
        err_beat  = eb;
        beat_cnt  = 0;
        base_addr = b;
        length    = LEN_W'(n);
        fill_data = f;
        data_inc  = inc;
        start     = 1'b1;
        @(negedge HCLK);
        start     = 1'b0;
        // scramble the inputs: the run must use the values sampled with start
        base_addr = $urandom();
        length    = LEN_W'($urandom_range(1, 50));
        fill_data = $urandom();
        data_inc  = $urandom();
        cyc = 1;
        if (n > 0) begin
            check("start_busy", busy, 1'b1);
            check("start_htrans", HTRANS, 2'b10);
            check("start_haddr", HADDR, b);
            check("start_error_clr", error, 1'b0);
        end else begin
            check("empty_htrans", HTRANS, 2'b00);
            check("empty_busy", busy, 1'b0);
        end
        while (!done && cyc < 4000) begin
            @(negedge HCLK);
            cyc++;
            if (mid_start && cyc == 3) begin
                start     = 1'b1;
                base_addr = 32'hDEAD_0000;
                length    = LEN_W'(7);
                fill_data = 32'hBAD0_0000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            fail("done_timeout", $sformatf("no done within %0d cycles", cyc));
        end else if (exp_done >= 0) begin
            check("done_cycle", cyc, exp_done);
        end
        @(negedge HCLK);
        check("done_one_cycle", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("error_hold", error, exp_err);
        if (n == 0) check("empty_idle_after", HTRANS, 2'b00);
        check("writes_missing", exp_q.size(), 0);
        exp_q.delete();
        exp_end_q.delete();
        err_beat = -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rb;
        int          rn;
        int          re;
        bit          rm;

        // reset values
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // zero wait states: NONSEQ cycles 1..4, done at cycle 6
        run(32'h5000_0010, 4, 32'h11, 32'h1, -1, 6, 1'b0);

        // three wait states on the data phase of beat 2 -> done at cycle 9
        wait_beat = 2;
        wait_n    = 3;
        run(32'h5000_0010, 4, 32'h11, 32'h1, -1, 9, 1'b0);
        wait_beat = -1;
        wait_n    = 0;

        // ERROR on beat 1 data phase: beat 2 never issued, done+error at cycle 5
        run(32'h5000_0010, 4, 32'h11, 32'h1, 1, 5, 1'b0);

        // empty run right after the error clears error, done at cycle 1
        run(32'h1234_5678, 0, 32'hAA, 32'h0, -1, 1, 1'b0);

        // error on the final beat (LAST) of a single-beat run
        run(32'h0000_0100, 1, 32'hCAFE, 32'h0, 0, 4, 1'b0);

        // constant fill with start pulsed mid-run (ignored)
        run(32'h2000_0000, 4, 32'h5A5A_5A5A, 32'h0, -1, 6, 1'b1);

        // address and data wrap-around
        run(32'hFFFF_FFFC, 2, 32'hFFFF_FFFF, 32'h1, -1, 4, 1'b0);

        // reset mid-run
        for (int k = 0; k < 10; k++)
            exp_q.push_back({32'h3000_0000 + 32'(k * ADDR_STEP), 32'h100 + 32'(k)});
        exp_end_q.push_back(1'b0);
        @(negedge HCLK);
        beat_cnt  = 0;
        base_addr = 32'h3000_0000;
        length    = LEN_W'(10);
        fill_data = 32'h100;
        data_inc  = 32'h1;
        start     = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("midrst_htrans", HTRANS, 2'b00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_haddr", HADDR, 32'h0);
        check("midrst_hwdata", HWDATA, 32'h0);
        exp_q.delete();
        exp_end_q.delete();
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        run(32'h5000_0010, 4, 32'h11, 32'h1, -1, 6, 1'b0);

        // randomized runs with wait states, bus stalls and errors
        rand_waits  = 1'b1;
        idle_stalls = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rb = $urandom() & 32'hFFFF_FFFC;
            rn = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
            re = (rn > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            rm = (rn >= 2) && ($urandom_range(0, 1) == 1);
            run(rb, rn, $urandom(), $urandom(), re, -1, rm);
        end
        rand_waits  = 1'b0;
        idle_stalls = 1'b0;

        // long run past 8-bit counts, zero wait: done at N+2
        run(32'h4000_0000, 300, 32'h0, 32'h0101_0101, -1, 302, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #900000;
        fail("global_timeout", "simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit");
    end

endmodule
